// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: multi-cycle phase sequencer for the MIPS core.
// Steps each instruction through IF, ID, EX, optional MEM and WB, and issues
// one-cycle enable strobes so the whole datapath runs on the single clock.
// Also handles memory-ready waits with a timeout, single-step, halt and
// exception stop.
module cpu_cycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             step_mode,
  input  logic             step_pulse,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             is_mem_op,
  input  logic             is_wb,
  input  logic             exception,
  output logic             imem_req,
  output logic             ir_en,
  output logic             dec_en,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             rf_we_en,
  output logic             pc_en,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_IF        = 3'd1,
    S_ID        = 3'd2,
    S_EX        = 3'd3,
    S_MEM       = 3'd4,
    S_WB        = 3'd5,
    S_STEP_WAIT = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  // Last wait cycle allowed before a memory access is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic       mem_q;
  logic       wb_q;
  logic       timeout_q;
  logic       set_timeout;

  // Next-state selection and Moore strobe decode for the current phase.
  always_comb begin
    next_state  = state;
    set_timeout = 1'b0;
    imem_req    = 1'b0;
    ir_en       = 1'b0;
    dec_en      = 1'b0;
    alu_en      = 1'b0;
    dmem_req    = 1'b0;
    rf_we_en    = 1'b0;
    pc_en       = 1'b0;
    halted      = 1'b0;
    case (state)
      S_IDLE: begin
        if (halt_req)  next_state = S_HALT;
        else if (run)  next_state = S_IF;
      end
      S_IF: begin
        imem_req = 1'b1;
        ir_en    = imem_ready;
        if (imem_ready) begin
          next_state = S_ID;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state  = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_ID: begin
        dec_en     = 1'b1;
        next_state = S_EX;
      end
      S_EX: begin
        alu_en = 1'b1;
        if (exception)  next_state = S_HALT;
        else if (mem_q) next_state = S_MEM;
        else            next_state = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          next_state = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state  = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_WB: begin
        pc_en    = 1'b1;
        rf_we_en = wb_q;
        if (halt_req)       next_state = S_HALT;
        else if (step_mode) next_state = S_STEP_WAIT;
        else                next_state = S_IF;
      end
      S_STEP_WAIT: begin
        if (halt_req)                     next_state = S_HALT;
        else if (step_pulse || !step_mode) next_state = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
        if (run && !timeout_q && !halt_req) next_state = S_IF;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State, wait counter, decoder flags, sticky timeout and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      mem_q       <= 1'b0;
      wb_q        <= 1'b0;
      timeout_q   <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        wait_cnt <= 8'd0;
      end else if ((state == S_IF && !imem_ready) || (state == S_MEM && !dmem_ready)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == S_ID) begin
        mem_q <= is_mem_op;
        wb_q  <= is_wb;
      end
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end
      if (state == S_WB) begin
        instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign phase   = state;
  assign busy    = (state == S_IF) || (state == S_ID) || (state == S_EX) ||
                   (state == S_MEM) || (state == S_WB);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// tb_cpu_cycle_sequencer: vector table plus hand-written corner sequences.
// Each vector drives one cycle of inputs and pushes the expected outputs for
// that cycle; the outputs are popped and compared half a cycle later.
module tb_cpu_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, halt_req, step_mode, step_pulse;
  logic        imem_ready, dmem_ready, is_mem_op, is_wb, exception;
  logic        imem_req, ir_en, dec_en, alu_en, dmem_req, rf_we_en, pc_en;
  logic [2:0]  phase;
  logic        busy, halted, timeout;
  logic [31:0] instr_count;

  // Input bit order: reset run halt_req step_mode step_pulse imem_ready
  //                  dmem_ready is_mem_op is_wb exception
  typedef struct packed {
    logic [9:0]  in;
    logic [2:0]  ph;
    logic        rfwe;
    logic        tmo;
    logic [31:0] cnt;
  } vec_t;

  typedef struct packed {
    logic [2:0]  ph;
    logic [9:0]  flags;
    logic [31:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  cpu_cycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
    .step_mode(step_mode), .step_pulse(step_pulse), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .is_mem_op(is_mem_op), .is_wb(is_wb),
    .exception(exception), .imem_req(imem_req), .ir_en(ir_en),
    .dec_en(dec_en), .alu_en(alu_en), .dmem_req(dmem_req),
    .rf_we_en(rf_we_en), .pc_en(pc_en), .phase(phase), .busy(busy),
    .halted(halted), .timeout(timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Flag order: imem_req ir_en dec_en alu_en dmem_req rf_we_en pc_en busy halted timeout
  function automatic logic [9:0] spec_flags(input logic [2:0] ph, input logic ir,
                                            input logic rfwe, input logic tmo);
    return {ph == 3'd1, (ph == 3'd1) && ir, ph == 3'd2, ph == 3'd3, ph == 3'd4,
            (ph == 3'd5) && rfwe, ph == 3'd5, (ph >= 3'd1) && (ph <= 3'd5),
            ph == 3'd7, tmo};
  endfunction

  task automatic add_vec(input logic [9:0] i, input logic [2:0] ph,
                         input logic rfwe, input logic tmo, input int cnt);
    vec_t v;
    v.in = i; v.ph = ph; v.rfwe = rfwe; v.tmo = tmo; v.cnt = 32'(cnt);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    {reset, run, halt_req, step_mode, step_pulse, imem_ready, dmem_ready,
     is_mem_op, is_wb, exception} = v.in;
    e.ph    = v.ph;
    e.flags = spec_flags(v.ph, v.in[4], v.rfwe, v.tmo);
    e.cnt   = v.cnt;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [9:0] act;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard @%0t: no expected entry queued", $time);
      return;
    end
    e   = exp_q.pop_front();
    act = {imem_req, ir_en, dec_en, alu_en, dmem_req, rf_we_en, pc_en, busy, halted, timeout};
    if (phase !== e.ph) begin
      fails++;
      $display("[TB] FAIL phase @%0t: got %0d expected %0d", $time, phase, e.ph);
    end
    tests++;
    if (act !== e.flags) begin
      fails++;
      $display("[TB] FAIL strobes @%0t (phase %0d): got %b expected %b", $time, e.ph, act, e.flags);
    end
    tests++;
    if (instr_count !== e.cnt) begin
      fails++;
      $display("[TB] FAIL instr_count @%0t: got %0d expected %0d", $time, instr_count, e.cnt);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk);
    #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic step(input logic [9:0] i, input logic [2:0] ph,
                      input logic rfwe, input logic tmo, input int cnt);
    vec_t v;
    v.in = i; v.ph = ph; v.rfwe = rfwe; v.tmo = tmo; v.cnt = 32'(cnt);
    run_vec(v);
  endtask

  initial begin
    {reset, run, halt_req, step_mode, step_pulse, imem_ready, dmem_ready,
     is_mem_op, is_wb, exception} = 10'b1_0_0_0_0_0_0_0_0_0;

    // Reset, then three back-to-back non-memory instructions, halt at last WB.
    add_vec(10'b1_0_0_0_0_0_0_0_0_0, 3'd0, 1'b0, 1'b0, 0);
    add_vec(10'b1_0_0_0_0_0_0_0_0_0, 3'd0, 1'b0, 1'b0, 0);
    add_vec(10'b0_1_0_0_0_1_0_0_1_0, 3'd0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      add_vec(10'b0_0_0_0_0_1_0_0_1_0, 3'd1, 1'b0, 1'b0, k);
      add_vec(10'b0_0_0_0_0_1_0_0_1_0, 3'd2, 1'b0, 1'b0, k);
      add_vec(10'b0_0_0_0_0_1_0_0_1_0, 3'd3, 1'b0, 1'b0, k);
      add_vec((k == 2) ? 10'b0_0_1_0_0_1_0_0_1_0 : 10'b0_0_0_0_0_1_0_0_1_0, 3'd5, 1'b1, 1'b0, k);
    end
    add_vec(10'b0_0_0_0_0_1_0_0_1_0, 3'd7, 1'b0, 1'b0, 3);

    // Memory instruction with three dmem wait cycles, no register write.
    add_vec(10'b0_1_0_0_0_1_0_0_0_0, 3'd7, 1'b0, 1'b0, 3);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd1, 1'b0, 1'b0, 3);
    add_vec(10'b0_0_0_0_0_1_0_1_0_0, 3'd2, 1'b0, 1'b0, 3);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd3, 1'b0, 1'b0, 3);
    for (int k = 0; k < 3; k++)
      add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd4, 1'b0, 1'b0, 3);
    add_vec(10'b0_0_0_0_0_1_1_0_0_0, 3'd4, 1'b0, 1'b0, 3);
    add_vec(10'b0_0_1_0_0_1_0_0_0_0, 3'd5, 1'b0, 1'b0, 3);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd7, 1'b0, 1'b0, 4);

    // Exception in EX: straight to HALT, no WB.
    add_vec(10'b0_1_0_0_0_1_0_0_0_0, 3'd7, 1'b0, 1'b0, 4);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd1, 1'b0, 1'b0, 4);
    add_vec(10'b0_0_0_0_0_1_0_0_1_0, 3'd2, 1'b0, 1'b0, 4);
    add_vec(10'b0_0_0_0_0_1_0_0_0_1, 3'd3, 1'b0, 1'b0, 4);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd7, 1'b0, 1'b0, 4);

    // halt_req raised in ID: instruction still retires, then HALT, then resume.
    add_vec(10'b0_1_0_0_0_1_0_0_0_0, 3'd7, 1'b0, 1'b0, 4);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd1, 1'b0, 1'b0, 4);
    add_vec(10'b0_0_1_0_0_1_0_0_1_0, 3'd2, 1'b0, 1'b0, 4);
    add_vec(10'b0_0_1_0_0_1_0_0_0_0, 3'd3, 1'b0, 1'b0, 4);
    add_vec(10'b0_0_1_0_0_1_0_0_0_0, 3'd5, 1'b1, 1'b0, 4);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd7, 1'b0, 1'b0, 5);
    add_vec(10'b0_1_0_0_0_1_0_0_0_0, 3'd7, 1'b0, 1'b0, 5);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd1, 1'b0, 1'b0, 5);

    // Single-step: wait in STEP_WAIT, two pulses, then halt_req from STEP_WAIT.
    add_vec(10'b0_0_0_0_0_1_0_0_1_0, 3'd2, 1'b0, 1'b0, 5);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd3, 1'b0, 1'b0, 5);
    add_vec(10'b0_0_0_1_0_1_0_0_0_0, 3'd5, 1'b1, 1'b0, 5);
    add_vec(10'b0_0_0_1_0_1_0_0_0_0, 3'd6, 1'b0, 1'b0, 6);
    add_vec(10'b0_0_0_1_0_1_0_0_0_0, 3'd6, 1'b0, 1'b0, 6);
    add_vec(10'b0_0_0_1_1_1_0_0_0_0, 3'd6, 1'b0, 1'b0, 6);
    for (int j = 0; j < 2; j++) begin
      add_vec(10'b0_0_0_1_0_1_0_0_0_0, 3'd1, 1'b0, 1'b0, 6 + j);
      add_vec(10'b0_0_0_1_0_1_0_0_1_0, 3'd2, 1'b0, 1'b0, 6 + j);
      add_vec(10'b0_0_0_1_0_1_0_0_0_0, 3'd3, 1'b0, 1'b0, 6 + j);
      add_vec(10'b0_0_0_1_0_1_0_0_0_0, 3'd5, 1'b1, 1'b0, 6 + j);
      add_vec((j == 0) ? 10'b0_0_0_1_1_1_0_0_0_0 : 10'b0_0_1_1_0_1_0_0_0_0, 3'd6, 1'b0, 1'b0, 7 + j);
    end
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd7, 1'b0, 1'b0, 8);

    // Dropping step_mode while in STEP_WAIT releases without a pulse.
    add_vec(10'b0_1_0_0_0_1_0_0_0_0, 3'd7, 1'b0, 1'b0, 8);
    add_vec(10'b0_0_0_1_0_1_0_0_0_0, 3'd1, 1'b0, 1'b0, 8);
    add_vec(10'b0_0_0_1_0_1_0_0_1_0, 3'd2, 1'b0, 1'b0, 8);
    add_vec(10'b0_0_0_1_0_1_0_0_0_0, 3'd3, 1'b0, 1'b0, 8);
    add_vec(10'b0_0_0_1_0_1_0_0_0_0, 3'd5, 1'b1, 1'b0, 8);
    add_vec(10'b0_0_0_0_0_1_0_0_0_0, 3'd6, 1'b0, 1'b0, 9);
    add_vec(10'b0_0_0_0_0_0_0_0_0_0, 3'd1, 1'b0, 1'b0, 9);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while in IF aborts the fetch and clears the counter.
    step(10'b1_0_0_0_0_0_0_0_0_0, 3'd1, 1'b0, 1'b0, 9);
    step(10'b0_1_0_0_0_0_0_0_0_0, 3'd0, 1'b0, 1'b0, 0);

    // IF timeout: exactly 16 not-ready cycles, then sticky HALT that ignores run.
    for (int k = 0; k < 16; k++) step(10'b0_0_0_0_0_0_0_0_0_0, 3'd1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++)  step(10'b0_1_0_0_0_0_0_0_0_0, 3'd7, 1'b0, 1'b1, 0);
    step(10'b1_0_0_0_0_0_0_0_0_0, 3'd7, 1'b0, 1'b1, 0);
    step(10'b0_1_0_0_0_0_0_0_0_0, 3'd0, 1'b0, 1'b0, 0);

    // Ready arriving on the final wait cycle beats the timeout.
    for (int k = 0; k < 15; k++) step(10'b0_0_0_0_0_0_0_0_0_0, 3'd1, 1'b0, 1'b0, 0);
    step(10'b0_0_0_0_0_1_0_0_0_0, 3'd1, 1'b0, 1'b0, 0);
    step(10'b0_0_0_0_0_0_0_1_1_0, 3'd2, 1'b0, 1'b0, 0);
    step(10'b0_0_0_0_0_0_0_0_0_0, 3'd3, 1'b0, 1'b0, 0);

    // MEM timeout: 16 not-ready data cycles, HALT with no retirement.
    for (int k = 0; k < 16; k++) step(10'b0_0_0_0_0_0_0_0_0_0, 3'd4, 1'b0, 1'b0, 0);
    step(10'b0_1_0_0_0_0_0_0_0_0, 3'd7, 1'b0, 1'b1, 0);
    step(10'b1_0_0_0_0_0_0_0_0_0, 3'd7, 1'b0, 1'b1, 0);
    step(10'b0_0_0_0_0_0_0_0_0_0, 3'd0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
